// File: rtl/trapezoid_window_acc.sv
// Sums WINDOW consecutive trapezoid surfaces and emits each window total with a one-cycle strobe.
// Optional macro TRAP_ACC_SATURATE_EN: clamp each add at 2^ACC_W-1 and report a sticky overflow.
module trapezoid_window_acc #(
  parameter int WINDOW = 1024,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [31:0]      surf_in,
  input  logic             surf_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             ovf_out,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc_out;
  logic             r_acc_valid;
  logic             w_take;
  logic             w_last;
  logic [ACC_W-1:0] w_base;
  logic [ACC_W-1:0] w_surf_ext;
  logic [ACC_W-1:0] w_sum;

  assign w_take     = surf_valid & ~clr;
  assign w_surf_ext = {{(ACC_W-32){1'b0}}, surf_in};
  // A window opening from IDLE starts from zero, so the load is just 0 + surf_in.
  assign w_base     = (r_state == S_IDLE) ? '0 : r_acc;

  always_comb begin
    w_last = 1'b0;
    if (w_take) begin
      if (r_state == S_IDLE) w_last = (WINDOW == 1);
      else                   w_last = (r_cnt == CNT_W'(WINDOW - 1));
    end
  end

`ifdef TRAP_ACC_SATURATE_EN
  logic [ACC_W:0] w_sum_ext;
  logic           w_ovf_acc;
  logic           r_ovf;
  logic           r_ovf_out;

  always_comb begin
    w_sum_ext = {1'b0, w_base} + {1'b0, w_surf_ext};
    w_sum     = w_sum_ext[ACC_W] ? '1 : w_sum_ext[ACC_W-1:0];
    w_ovf_acc = w_sum_ext[ACC_W] | ((r_state == S_ACCUM) & r_ovf);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf     <= 1'b0;
      r_ovf_out <= 1'b0;
    end else if (clr) begin
      r_ovf     <= 1'b0;
    end else if (w_last) begin
      r_ovf     <= 1'b0;
      r_ovf_out <= w_ovf_acc;
    end else if (w_take) begin
      r_ovf     <= w_ovf_acc;
    end
  end

  assign ovf_out = r_ovf_out;
`else
  assign w_sum   = w_base + w_surf_ext;
  assign ovf_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (clr || w_last)  w_state_next = S_IDLE;
    else if (w_take)    w_state_next = S_ACCUM;
  end

  always_comb begin
    busy      = (r_state == S_ACCUM);
    count     = r_cnt;
    acc_out   = r_acc_out;
    acc_valid = r_acc_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_acc_out   <= '0;
      r_acc_valid <= 1'b0;
    end else begin
      r_acc_valid <= w_last;
      if (clr) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (w_last) begin
        r_acc_out <= w_sum;
        r_acc     <= '0;
        r_cnt     <= '0;
      end else if (w_take) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/trapezoid_window_acc.md
# trapezoid_window_acc

Downstream consumer of the trapezoid surface stage: sums consecutive trapezoid surfaces (`surf`/`valid` pairs) over a fixed window of WINDOW samples to form a numerical integral. On the last sample of each window it emits the full-width sum with a one-cycle strobe, then restarts without a dead cycle. It feeds result registers and the control logic that reads the integral.

## Interface
- WINDOW, 1024: surfaces per integration window; legal range 1..65535.
- ACC_W, 48: accumulator and result width; legal range 33..64.
- CNT_W, $clog2(WINDOW+1): width of the `count` output; derived, do not override.
- clk  in  1: system clock, all logic on rising edge.
- rst  in  1: asynchronous, active-high reset.
- clr  in  1: synchronous clear; discards the partial window.
- surf_in  in  32: unsigned trapezoid surface from the upstream stage.
- surf_valid  in  1: `surf_in` is valid this cycle; one sample per asserted cycle, no backpressure.
- acc_out  out  ACC_W: unsigned sum of the last completed window.
- acc_valid  out  1: single-cycle strobe, `acc_out` just updated.
- ovf_out  out  1: the window reported in `acc_out` overflowed ACC_W.
- count  out  CNT_W: samples accepted in the current window (0..WINDOW-1).
- busy  out  1: high while a window is open (state ACCUM).

## Operation
- States:
  - IDLE: no window open.
  - ACCUM: window open.
- Running registers: `acc` (ACC_W), `cnt` (CNT_W), `ovf` (1).
- IDLE + `surf_valid`:
  - Load `acc = surf_in`, `cnt = 1`, `ovf = 0`.
  - WINDOW==1 is the last sample case below.
  - Otherwise go to ACCUM.
- ACCUM + `surf_valid`, not last sample: `acc += surf_in` (zero-extended), `cnt += 1`.
- Last sample (accepted sample is the WINDOW-th):
  - Register the final sum into `acc_out` and the final overflow into `ovf_out`.
  - Pulse `acc_valid`.
  - Go to IDLE with `cnt = 0`.
- ACCUM, `surf_valid` low: hold all state. Gaps are unlimited.
- `clr`:
  - Has priority over `surf_valid` in the same cycle; that sample is dropped.
  - Forces IDLE with `acc = 0`, `cnt = 0`, `ovf = 0`.
  - `acc_out` and `ovf_out` are untouched; no `acc_valid` pulse.
- `count` = `cnt`; `busy` = (state == ACCUM).
- Arithmetic is unsigned. Overflow handling is set by the configuration macro.

## Timing
- Reset values: `acc_out` = 0, `acc_valid` = 0, `ovf_out` = 0, `count` = 0, `busy` = 0, state IDLE.
- Latency: last sample accepted at edge N gives `acc_out`, `ovf_out` and `acc_valid`=1 visible after edge N (registered, 1 cycle). `acc_valid` returns to 0 after edge N+1 unless that edge completes another window, which is possible only when WINDOW==1.
- Back-to-back: a `surf_valid` on the cycle right after the last sample opens the next window. Throughput is one sample per clock.
- `acc_out` holds its value until the next completed window.
- `rst` asserted mid-window: immediate return to reset values; the partial sum is lost.

## Configuration
- `TRAP_ACC_SATURATE_EN` defined:
  - Each add clamps at 2^ACC_W-1.
  - A clamp sets `ovf`, which stays sticky until the window ends.
  - `ovf_out` reports it with the result.
- Not defined:
  - The accumulator wraps modulo 2^ACC_W.
  - `ovf_out` is constant 0.
  - No clamp logic is synthesized.

## Test plan
- WINDOW=4, ACC_W=48: `surf_in` 8, 16, 24, 32 on consecutive cycles -> one cycle after the 4th sample, `acc_out`=80 and `acc_valid`=1 for exactly one cycle; `count` sequence 1,2,3,0; `busy` drops with the strobe.
- WINDOW=4: same four values with 0-3 idle cycles between them -> `acc_out`=80, strobe one cycle after the 4th sample, `count` stable during the gaps.
- WINDOW=4: samples 5, 5, then `clr` together with a valid 7, then 1, 2, 3, 4 -> `acc_out`=10; the previous `acc_out` is held through the clear.
- WINDOW=2: 8 consecutive valids of value 3 -> `acc_valid` strobes on every second cycle, each `acc_out`=6, no lost samples.
- WINDOW=4, ACC_W=33: four samples of 0xFFFFFFFF.
  - With `TRAP_ACC_SATURATE_EN`: `acc_out`=0x1_FFFF_FFFF, `ovf_out`=1.
  - Without the macro: `acc_out`=0x1_FFFF_FFFC, `ovf_out`=0.
  - A following window of 1,1,1,1: `acc_out`=4, `ovf_out`=0.
- `rst` pulsed after 2 of 4 samples -> all outputs 0 immediately; the next 4 samples of 10 give `acc_out`=40.
